// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-side fetch path and
// the D-side load/store path. D-side has priority, bounded by a starvation
// limit so the I-side always makes progress. Each grant issues one access,
// waits the fixed memory latency, then pulses done for one cycle.
// Optional wait-cycle performance counters: define ARB_PERF_CNT_EN.
module mem_arbiter #(
  parameter int MEM_LAT    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_done,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        err,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_stall,
  input  logic [15:0] mem_rdata,
  input  logic        mem_err,
  output logic [15:0] perf_i_wait,
  output logic [15:0] perf_d_wait
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int LAT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam int STV_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  logic [1:0]       stateReg, stateNext;
  logic             winnerDReg;
  logic [LAT_W-1:0] latCntReg;
  logic [STV_W-1:0] starveReg;
  logic             anyReq;
  logic             dWins;
  logic             inIssue;
  logic             inResp;

  assign anyReq  = i_req | d_req;
  // D keeps priority until I has been passed over STARVE_MAX times in a row.
  assign dWins   = d_req && (!i_req || (starveReg < STV_W'(STARVE_MAX)));
  assign inIssue = (stateReg == ISSUE);
  assign inResp  = (stateReg == RESP);

  // Next-state selection; a grant always runs to RESP, never preempted.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (anyReq) stateNext = ISSUE;
      ISSUE:   if (!mem_stall) stateNext = (MEM_LAT == 1) ? RESP : WAIT;
      WAIT:    if (latCntReg == LAT_W'(1)) stateNext = RESP;
      default: stateNext = IDLE;
    endcase
  end

  // State, winner capture, latency countdown and starvation tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg   <= IDLE;
      winnerDReg <= 1'b0;
      latCntReg  <= '0;
      starveReg  <= '0;
    end else begin
      stateReg <= stateNext;
      if (stateReg == IDLE && anyReq) begin
        winnerDReg <= dWins;
        if (dWins && i_req) begin
          if (starveReg != STV_W'(STARVE_MAX)) starveReg <= starveReg + STV_W'(1);
        end else begin
          starveReg <= '0;
        end
      end else if (!i_req) begin
        starveReg <= '0;
      end
      // Load on acceptance so RESP lands exactly MEM_LAT cycles later.
      if (inIssue && !mem_stall) latCntReg <= LAT_W'(MEM_LAT - 1);
      else if (stateReg == WAIT) latCntReg <= latCntReg - LAT_W'(1);
    end
  end

  // Memory strobes come from the winner's live inputs only while issuing.
  always_comb begin
    mem_rd    = inIssue && (!winnerDReg || !d_wr);
    mem_wr    = inIssue && winnerDReg && d_wr;
    mem_addr  = inIssue ? (winnerDReg ? d_addr : i_addr) : 16'h0000;
    mem_wdata = (inIssue && winnerDReg && d_wr) ? d_wdata : 16'h0000;
  end

  // Response path: done to the winner, read data passed straight through.
  always_comb begin
    i_done  = inResp && !winnerDReg;
    d_done  = inResp && winnerDReg;
    i_rdata = i_done ? mem_rdata : 16'h0000;
    d_rdata = (d_done && !d_wr) ? mem_rdata : 16'h0000;
    err     = inResp && mem_err;
  end

`ifdef ARB_PERF_CNT_EN
  logic        activeI, activeD;
  logic [15:0] perfIReg, perfDReg;

  // In IDLE the side being granted this cycle counts as the active winner.
  assign activeI = (stateReg == IDLE) ? (anyReq && !dWins) : !winnerDReg;
  assign activeD = (stateReg == IDLE) ? dWins : winnerDReg;

  // Wait-cycle counters, wrapping at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perfIReg <= 16'h0000;
      perfDReg <= 16'h0000;
    end else begin
      if (i_req && !activeI) perfIReg <= perfIReg + 16'h0001;
      if (d_req && !activeD) perfDReg <= perfDReg + 16'h0001;
    end
  end

  assign perf_i_wait = perfIReg;
  assign perf_d_wait = perfDReg;
`else
  assign perf_i_wait = 16'h0000;
  assign perf_d_wait = 16'h0000;
`endif

endmodule
